// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared definitions for the LSU data memory controller.
//   memc_state_e : controller FSM states (2-bit)
//   memc_op_e    : latched request operation
//   idx_width()  : index width helper that never returns 0
package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MEMC_IDLE   = 2'd0,
    MEMC_ACCESS = 2'd1,
    MEMC_ACK    = 2'd2
  } memc_state_e;

  typedef enum logic {
    MEMC_OP_READ  = 1'b0,
    MEMC_OP_WRITE = 1'b1
  } memc_op_e;

  // Bits needed to index n items; at least 1 so single-entry cases stay legal.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   eligible    in  NUM_LANES  lanes requesting service
//   ptr         in  IDX_W      lane with highest priority this cycle
//   grant       out NUM_LANES  one-hot grant (0 when nothing eligible)
//   grant_idx   out IDX_W      index of the granted lane
//   grant_valid out 1          some lane is eligible
module rr_arbiter
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  localparam int unsigned IDX_W = idx_width(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] eligible,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [NUM_LANES-1:0] rot;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    // Rotate so bit 0 is the lane at ptr; first set bit upward wins.
    rot         = NUM_LANES'({eligible, eligible} >> ptr);
    sum         = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (rot[i] && !grant_valid) begin
        grant_valid = 1'b1;
        sum = {1'b0, ptr} + SUM_W'(i);
        if (sum >= SUM_W'(NUM_LANES)) sum = sum - SUM_W'(NUM_LANES);
        grant_idx = sum[IDX_W-1:0];
      end
    end
    grant = grant_valid ? (NUM_LANES'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: responder for the per-lane LSU valid/ack memory handshake.
// Lanes are arbitrated round-robin onto one single-port word array; each
// serviced request gets a one-cycle read or write ack.
//   clk, rst          clock; synchronous active-high reset
//   lane_read_valid   per-lane read request, held until ack
//   lane_write_valid  per-lane write request, held until ack
//   lane_addr         flattened per-lane addresses
//   lane_write_data   flattened per-lane write data
//   lane_read_ack     one-cycle read completion pulse
//   lane_write_ack    one-cycle write completion pulse
//   lane_read_data    flattened per-lane read data, held until next read ack
//   busy              controller not idle
//   bad_addr_err      pulses in the ack cycle of an out-of-range access when
//                     DATA_MEM_BOUNDS_CHECK_EN is defined, else tied 0
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 4,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 7,
  parameter int unsigned DEPTH         = 128,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            lane_read_valid,
  input  logic [NUM_LANES-1:0]            lane_write_valid,
  input  logic [NUM_LANES*ADDR_WIDTH-1:0] lane_addr,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_write_data,
  output logic [NUM_LANES-1:0]            lane_read_ack,
  output logic [NUM_LANES-1:0]            lane_write_ack,
  output logic [NUM_LANES*DATA_WIDTH-1:0] lane_read_data,
  output logic                            busy,
  output logic                            bad_addr_err
);

  localparam int unsigned IDX_W  = idx_width(NUM_LANES);
  localparam int unsigned CNT_W  = idx_width(ACCESS_CYCLES);
  localparam int unsigned MEM_AW = idx_width(DEPTH);

  memc_state_e                     state_q, state_d;
  memc_op_e                        op_q, op_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]                lane_q, lane_d;
  logic [IDX_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [NUM_LANES-1:0]            served_q, served_d;
  logic [NUM_LANES*DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  in_range;

  logic [NUM_LANES-1:0]  lane_req, eligible, grant, lane_onehot;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_wr;

  assign lane_req    = lane_read_valid | lane_write_valid;
  assign eligible    = lane_req & ~served_q;
  assign lane_onehot = NUM_LANES'(1) << lane_q;
  assign in_range    = 32'(addr_q) < DEPTH;
  assign mem_rdata   = mem[addr_q[MEM_AW-1:0]];

  rr_arbiter #(
    .NUM_LANES(NUM_LANES)
  ) u_arb (
    .eligible   (eligible),
    .ptr        (rr_ptr_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    lane_d    = lane_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    served_d  = served_q;

    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) begin
        sel_addr  = lane_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = lane_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wr    = lane_write_valid[i];
      end
    end

    unique case (state_q)
      MEMC_IDLE: begin
        if (grant_valid) begin
          state_d  = MEMC_ACCESS;
          lane_d   = grant_idx;
          op_d     = sel_wr ? MEMC_OP_WRITE : MEMC_OP_READ;  // write wins when both set
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          cnt_d    = CNT_W'(ACCESS_CYCLES - 1);
          rr_ptr_d = (grant_idx == IDX_W'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      MEMC_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = MEMC_ACK;
          if (op_q == MEMC_OP_WRITE) begin
            mem_we = in_range;
          end else begin
            // Captured straight into the lane's output register so the data is
            // already presented during the ack pulse.
            for (int i = 0; i < NUM_LANES; i++) begin
              if (lane_q == IDX_W'(i)) begin
                rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = in_range ? mem_rdata : '0;
              end
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MEMC_ACK: begin
        state_d  = MEMC_IDLE;
        served_d = served_q | lane_onehot;
      end
      default: state_d = MEMC_IDLE;
    endcase

    // A lane with both valids low is ready for a fresh request.
    served_d = served_d & lane_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MEMC_IDLE;
      op_q     <= MEMC_OP_READ;
      cnt_q    <= '0;
      lane_q   <= '0;
      rr_ptr_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      served_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      lane_q   <= lane_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      served_q <= served_d;
      rdata_q  <= rdata_d;
    end
  end

  // Array contents survive reset; a reset edge blocks the pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[addr_q[MEM_AW-1:0]] <= wdata_q;
    end
  end

  assign lane_read_ack  = (state_q == MEMC_ACK && op_q == MEMC_OP_READ)  ? lane_onehot : '0;
  assign lane_write_ack = (state_q == MEMC_ACK && op_q == MEMC_OP_WRITE) ? lane_onehot : '0;
  assign lane_read_data = rdata_q;
  assign busy           = state_q != MEMC_IDLE;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign bad_addr_err = (state_q == MEMC_ACK) && !in_range;
`else
  assign bad_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed scenarios plus random rounds.
module tb_data_mem_ctrl;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 7;
  localparam int unsigned DEPTH = 100;
  localparam int unsigned AC = 2;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [NL-1:0]      lane_read_valid, lane_write_valid;
  logic [NL*AW-1:0]   lane_addr;
  logic [NL*DW-1:0]   lane_write_data;
  logic [NL-1:0]      lane_read_ack, lane_write_ack;
  logic [NL*DW-1:0]   lane_read_data;
  logic               busy, bad_addr_err;

  data_mem_ctrl #(
    .NUM_LANES(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk), .rst(rst),
    .lane_read_valid(lane_read_valid), .lane_write_valid(lane_write_valid),
    .lane_addr(lane_addr), .lane_write_data(lane_write_data),
    .lane_read_ack(lane_read_ack), .lane_write_ack(lane_write_ack),
    .lane_read_data(lane_read_data), .busy(busy), .bad_addr_err(bad_addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_wr;
    logic [DW-1:0] data;
    bit            bad;
  } exp_t;

  typedef struct {
    int lane;
    int cyc;
  } ack_t;

  exp_t          exp_q[NL][$];
  ack_t          ack_log[$];
  logic [DW-1:0] model [DEPTH];
  int            checks = 0;
  int            failures = 0;

  bit            req_act[NL], req_rd[NL], req_wr[NL];
  int            req_addr[NL];
  logic [DW-1:0] req_data[NL];
  int            lat[NL];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: write takes priority, out-of-range reads give 0, writes vanish.
  task automatic push_exp(input int lane, input bit rd, input bit wr, input int addr,
                          input logic [DW-1:0] data);
    exp_t e;
    bit   inr;
    inr   = addr < DEPTH;
    e.bad = !inr && BOUNDS_EN;
    if (wr) begin
      e.is_wr = 1'b1;
      e.data  = '0;
      if (inr) model[addr] = data;
    end else begin
      e.is_wr = 1'b0;
      e.data  = (rd && inr) ? model[addr] : '0;
    end
    exp_q[lane].push_back(e);
  endtask

  // Monitor: pops the lane's expectation whenever an ack is presented.
  always @(negedge clk) begin
    int   nack;
    exp_t e;
    nack = 0;
    for (int i = 0; i < NL; i++) begin
      if (lane_read_ack[i] || lane_write_ack[i]) begin
        nack++;
        ack_log.push_back('{i, cyc});
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL ack_expected lane=%0d actual=ack required=none", i);
        end else begin
          e = exp_q[i].pop_front();
          check($sformatf("write_ack_l%0d", i), DW'(lane_write_ack[i]), DW'(e.is_wr));
          check($sformatf("read_ack_l%0d", i), DW'(lane_read_ack[i]), DW'(!e.is_wr));
          if (!e.is_wr) check($sformatf("read_data_l%0d", i), lane_read_data[i*DW +: DW], e.data);
          check("bad_addr_err_ack", DW'(bad_addr_err), DW'(e.bad));
          check("busy_in_ack", DW'(busy), 1);
        end
      end
    end
    if (nack == 0) check("bad_addr_err_idle", DW'(bad_addr_err), 0);
    if (nack > 1) check("acks_per_cycle", DW'(nack), 1);
  end

  task automatic clear_inputs();
    lane_read_valid  = '0;
    lane_write_valid = '0;
    lane_addr        = '0;
    lane_write_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    check("rst_read_ack", DW'(lane_read_ack), 0);
    check("rst_write_ack", DW'(lane_write_ack), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_bad_addr_err", DW'(bad_addr_err), 0);
    for (int i = 0; i < NL; i++) check("rst_read_data", lane_read_data[i*DW +: DW], 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives all active lanes at one edge, drops each valid after its ack.
  task automatic issue_round();
    logic [NL-1:0] pend;
    logic [NL-1:0] drop;
    int            edges;
    pend = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) begin
      lat[i] = -1;
      if (req_act[i]) begin
        push_exp(i, req_rd[i], req_wr[i], req_addr[i], req_data[i]);
        lane_read_valid[i]          = req_rd[i];
        lane_write_valid[i]         = req_wr[i];
        lane_addr[i*AW +: AW]       = AW'(req_addr[i]);
        lane_write_data[i*DW +: DW] = req_data[i];
        pend[i] = 1'b1;
      end
    end
    edges = 0;
    while (pend != '0 && edges < 100) begin
      @(negedge clk);
      drop = '0;
      for (int i = 0; i < NL; i++) begin
        if (pend[i] && (lane_read_ack[i] || lane_write_ack[i])) begin
          lat[i]  = edges;
          pend[i] = 1'b0;
          drop[i] = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      edges++;
      for (int i = 0; i < NL; i++) begin
        if (drop[i]) begin
          lane_read_valid[i]  = 1'b0;
          lane_write_valid[i] = 1'b0;
        end
      end
    end
    check("round_complete", DW'(pend), 0);
    clear_inputs();
  endtask

  task automatic single(input int lane, input bit rd, input bit wr, input int addr,
                        input logic [DW-1:0] data, input bit chk_lat);
    for (int i = 0; i < NL; i++) req_act[i] = 1'b0;
    req_act[lane]  = 1'b1;
    req_rd[lane]   = rd;
    req_wr[lane]   = wr;
    req_addr[lane] = addr;
    req_data[lane] = data;
    issue_round();
    if (chk_lat) check("latency", DW'(lat[lane]), AC + 1);
  endtask

  task automatic order_round(input int base);
    ack_log.delete();
    for (int i = 0; i < NL; i++) begin
      req_act[i]  = 1'b1;
      req_rd[i]   = 1'b1;
      req_wr[i]   = 1'b0;
      req_addr[i] = base + 11 * i;
      req_data[i] = '0;
    end
    issue_round();
    check("order_count", DW'(ack_log.size()), NL);
    for (int i = 0; i < NL && i < ack_log.size(); i++) begin
      check("order_lane", DW'(ack_log[i].lane), DW'(i));
      if (i > 0) check("order_spacing", DW'(ack_log[i].cyc - ack_log[i-1].cyc), AC + 2);
    end
  endtask

  initial begin
    int            nacks;
    int            op;
    logic [DW-1:0] d;

    rst = 1'b1;
    clear_inputs();
    do_reset();

    // Give every in-range word a known value.
    for (int a = 0; a < DEPTH; a++) single(a % NL, 1'b0, 1'b1, a, {$urandom, $urandom}, 1'b0);

    // Write then read back, isolated, with latency check.
    single(0, 1'b0, 1'b1, 5, 64'hDEAD_BEEF, 1'b1);
    single(0, 1'b1, 1'b0, 5, '0, 1'b1);

    // Round-robin order from a fresh pointer, then again after wrap.
    do_reset();
    order_round(10);
    order_round(14);

    // Valid held high: one ack only; re-request after a one-cycle drop.
    @(posedge clk);
    #1;
    d = {$urandom, $urandom};
    push_exp(2, 1'b0, 1'b1, 50, d);
    lane_write_valid[2]       = 1'b1;
    lane_addr[2*AW +: AW]     = AW'(50);
    lane_write_data[2*DW +: DW] = d;
    nacks = 0;
    repeat (20) begin
      @(negedge clk);
      if (lane_write_ack[2]) nacks++;
      @(posedge clk);
    end
    check("held_valid_acks", DW'(nacks), 1);
    #1 lane_write_valid[2] = 1'b0;
    @(posedge clk);
    #1;
    d = {$urandom, $urandom};
    push_exp(2, 1'b0, 1'b1, 50, d);
    lane_write_valid[2]         = 1'b1;
    lane_write_data[2*DW +: DW] = d;
    nacks = 0;
    repeat (20) begin
      @(negedge clk);
      if (lane_write_ack[2]) nacks++;
      @(posedge clk);
    end
    check("reasserted_valid_acks", DW'(nacks), 1);
    #1 clear_inputs();
    single(2, 1'b1, 1'b0, 50, '0, 1'b1);

    // Read and write together: write only.
    single(1, 1'b1, 1'b1, 9, 64'h55, 1'b1);
    single(1, 1'b1, 1'b0, 9, '0, 1'b1);

    // Reset during the first access cycle of a write: no commit.
    single(0, 1'b0, 1'b1, 3, 64'h11, 1'b0);
    @(posedge clk);
    #1;
    lane_write_valid[0]   = 1'b1;
    lane_addr[0 +: AW]    = AW'(3);
    lane_write_data[0 +: DW] = 64'h77;
    @(posedge clk);
    @(negedge clk);
    check("busy_in_access", DW'(busy), 1);
    do_reset();
    single(0, 1'b1, 1'b0, 3, '0, 1'b1);

    // Out-of-range accesses.
    single(0, 1'b1, 1'b0, 120, '0, 1'b1);
    single(1, 1'b0, 1'b1, 110, {$urandom, $urandom}, 1'b0);
    single(3, 1'b1, 1'b0, 127, '0, 1'b0);

    // Random concurrent rounds; each lane owns addresses congruent to its index.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NL; i++) begin
        req_act[i] = ($urandom_range(0, 3) != 0);
        op = int'($urandom_range(0, 2));
        req_rd[i] = (op != 1);
        req_wr[i] = (op != 0);
        if ($urandom_range(0, 7) == 0) req_addr[i] = int'($urandom_range(DEPTH, 127));
        else req_addr[i] = i + NL * int'($urandom_range(0, (DEPTH - 1 - i) / NL));
        req_data[i] = {$urandom, $urandom};
      end
      issue_round();
    end

    repeat (3) @(posedge clk);
    for (int i = 0; i < NL; i++) check("leftover_expected", DW'(exp_q[i].size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
